// File: rtl/clk1_result_pkg.sv
// Shared definitions for the clk_1 result receiver: state encoding, default widths
// and the minimum synchronizer depth.
package clk1_result_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_VALID = 1'b1;

    localparam int PKG_MSG_WIDTH       = 60;
    localparam int PKG_CRC_MAX         = 8;
    localparam int PKG_RESULT_WIDTH    = 68;
    localparam int PKG_SYNC_STAGES_MIN = 2;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_VALID = S_VALID
    } rx_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer, async active-low reset to 0.
// Shared by the result receiver (req toggle) and the sending side (ack toggle).
module cdc_sync_bit #(
    parameter int pSTAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [pSTAGES-1:0] sync_q;
    logic [pSTAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[pSTAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[pSTAGES-1];

endmodule

// File: rtl/clk1_result_receiver.sv
// clk_1-side receiver of the toggle-handshake result path, presenting results on valid/ready.
// Optional sticky protocol-error flag when CLK1_RX_PROTO_ERR_EN is defined.
module clk1_result_receiver
    import clk1_result_pkg::*;
#(
    parameter int pRESULT_WIDTH = PKG_RESULT_WIDTH,
    parameter int pSYNC_STAGES  = 2
) (
    input  logic                     clk_1,
    input  logic                     rst_n,
    input  logic                     res_req_toggle,
    input  logic [pRESULT_WIDTH-1:0] res_data,
    output logic                     res_ack_toggle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pRESULT_WIDTH-1:0] out_data,
    output logic                     busy
`ifdef CLK1_RX_PROTO_ERR_EN
    ,
    output logic                     proto_err
`endif
);

    logic req_sync;

    cdc_sync_bit #(
        .pSTAGES(pSYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_1),
        .rst_n (rst_n),
        .d     (res_req_toggle),
        .q     (req_sync)
    );

    rx_state_e                state_q, state_d;
    logic                     req_seen_q, req_seen_d;
    logic                     ack_q, ack_d;
    logic                     out_valid_q, out_valid_d;
    logic [pRESULT_WIDTH-1:0] out_data_q, out_data_d;
    logic                     req_event;

    // Toggle edges seen while VALID are left pending; req_seen only moves on capture.
    assign req_event = (req_sync != req_seen_q) && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        req_seen_d  = req_seen_q;
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_event) begin
                    out_data_d  = res_data;
                    req_seen_d  = req_sync;
                    out_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = ~ack_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_seen_q  <= 1'b0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_seen_q  <= req_seen_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign res_ack_toggle = ack_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign busy           = (state_q == ST_VALID);

`ifdef CLK1_RX_PROTO_ERR_EN
    logic req_sync_prev_q;
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q | ((state_q == ST_VALID) && (req_sync != req_sync_prev_q));
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_prev_q <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            req_sync_prev_q <= req_sync;
            proto_err_q     <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_clk1_result_receiver.sv
// Self-checking bench for clk1_result_receiver: directed latency/backpressure/reset cases
// plus randomized async-sender bursts checked against an in-order result queue.
`timescale 1ns/1ps
module tb_clk1_result_receiver;

    localparam int W = 68;

    logic         clk_1 = 1'b0;
    logic         clk_s = 1'b0;
    logic         rst_n = 1'b0;
    logic         res_req_toggle = 1'b0;
    logic [W-1:0] res_data = '0;
    logic         out_ready = 1'b0;
    logic         res_ack_toggle;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
`ifdef CLK1_RX_PROTO_ERR_EN
    logic         proto_err;
`endif

    clk1_result_receiver #(
        .pRESULT_WIDTH (W),
        .pSYNC_STAGES  (2)
    ) dut (
        .clk_1          (clk_1),
        .rst_n          (rst_n),
        .res_req_toggle (res_req_toggle),
        .res_data       (res_data),
        .res_ack_toggle (res_ack_toggle),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy)
`ifdef CLK1_RX_PROTO_ERR_EN
        ,
        .proto_err      (proto_err)
`endif
    );

    always #5    clk_1 = ~clk_1;
    always #3.65 clk_s = ~clk_s;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sender-side ack synchronizer (reference sender model).
    logic ack_s1 = 1'b0;
    logic ack_s2 = 1'b0;
    always @(posedge clk_s) begin
        ack_s1 <= res_ack_toggle;
        ack_s2 <= ack_s1;
    end

    // Burst-phase scoreboard: every toggle sent must come out once, in order, with one ack flip.
    bit           b2b_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           ack_flips = 0;
    logic         ack_prev = 1'b0;

    initial forever begin
        @(posedge clk_1);
        #2;
        if (b2b_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk_1);
        if (b2b_en) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (res_ack_toggle != ack_prev) ack_flips++;
        end
        ack_prev = res_ack_toggle;
    end

    task automatic send_burst(input int n, input bit rnd);
        logic [W-1:0] d;
        int budget;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_s);
            d = rnd ? W'({$urandom, $urandom, $urandom}) : W'(i + 1);
            res_data = d;
            exp_q.push_back(d);
            @(posedge clk_s);
            res_req_toggle = ~res_req_toggle;
            budget = 0;
            while (ack_s2 != res_req_toggle && budget < 400) begin
                @(posedge clk_s);
                budget++;
            end
            if (budget >= 400) check_val("burst_ack_wait", W'(ack_s2), W'(res_req_toggle));
            repeat ($urandom_range(0, 3)) @(posedge clk_s);
        end
    endtask

    task automatic run_burst(input string tag, input int n, input bit rnd);
        exp_q.delete();
        got_q.delete();
        ack_flips = 0;
        @(negedge clk_1);
        b2b_en = 1'b1;
        send_burst(n, rnd);
        repeat (6) @(negedge clk_1);
        b2b_en = 1'b0;
        out_ready = 1'b0;
        check_val({tag, "_count"}, W'(got_q.size()), W'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) check_val({tag, "_data"}, got_q[i], exp_q[i]);
        end
        check_val({tag, "_ack_flips"}, W'(ack_flips), W'(n));
        check_val({tag, "_ack_level"}, W'(res_ack_toggle), W'(n % 2));
        check_val({tag, "_idle"}, W'(out_valid), W'(0));
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 0;
        while (!out_valid && budget < 12) begin
            @(negedge clk_1);
            budget++;
        end
        check_val({tag, "_valid_rise"}, W'(out_valid), W'(1));
    endtask

    initial begin
        logic [W-1:0] val_a;
        logic [W-1:0] val_b;
        logic [W-1:0] ones;
        int           budget;

        // Reset then idle
        repeat (3) @(negedge clk_1);
        check_val("rst_valid", W'(out_valid), W'(0));
        check_val("rst_ack", W'(res_ack_toggle), W'(0));
        check_val("rst_data", out_data, W'(0));
        check_val("rst_busy", W'(busy), W'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1);
            check_val("idle_valid", W'(out_valid), W'(0));
            check_val("idle_ack", W'(res_ack_toggle), W'(0));
            check_val("idle_data", out_data, W'(0));
        end

        // Single transfer, exact latency with out_ready=1
        val_a = 68'h0_ABCD_1234_5678_9A;
        out_ready = 1'b1;
        res_data = val_a;
        res_req_toggle = 1'b1;
        @(posedge clk_1); #1;
        check_val("lat_e1_valid", W'(out_valid), W'(0));
        @(posedge clk_1); #1;
        check_val("lat_e2_valid", W'(out_valid), W'(0));
        @(posedge clk_1); #1;
        check_val("lat_e3_valid", W'(out_valid), W'(1));
        check_val("lat_e3_data", out_data, val_a);
        check_val("lat_e3_ack", W'(res_ack_toggle), W'(0));
        check_val("lat_e3_busy", W'(busy), W'(1));
        @(posedge clk_1); #1;
        check_val("lat_e4_valid", W'(out_valid), W'(0));
        check_val("lat_e4_ack", W'(res_ack_toggle), W'(1));
        repeat (3) @(negedge clk_1);
        check_val("lat_ack_hold", W'(res_ack_toggle), W'(1));

        // Backpressure: res_data changes while VALID must not leak through
        @(negedge clk_1);
        out_ready = 1'b0;
        val_a = W'({$urandom, $urandom, $urandom});
        res_data = val_a;
        res_req_toggle = 1'b0;
        wait_valid("bp");
        check_val("bp_data", out_data, val_a);
        ones = '1;
        res_data = ones;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_1);
            check_val("bp_hold_data", out_data, val_a);
            check_val("bp_hold_valid", W'(out_valid), W'(1));
            check_val("bp_hold_ack", W'(res_ack_toggle), W'(1));
        end
        out_ready = 1'b1;
        @(negedge clk_1);
        check_val("bp_accept_valid", W'(out_valid), W'(0));
        check_val("bp_accept_ack", W'(res_ack_toggle), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_1);
            check_val("bp_post_ack", W'(res_ack_toggle), W'(0));
            check_val("bp_post_valid", W'(out_valid), W'(0));
        end
        out_ready = 1'b0;

        // Async sender, values 1..8, then a randomized burst
        run_burst("b2b", 8, 1'b0);
        run_burst("rand", 20, 1'b1);

        // Toggle flipped twice around a VALID window: second edge is captured after return to IDLE
        @(negedge clk_1);
`ifdef CLK1_RX_PROTO_ERR_EN
        check_val("perr_clear", W'(proto_err), W'(0));
`endif
        out_ready = 1'b0;
        val_a = W'({$urandom, $urandom, $urandom});
        val_b = ~val_a;
        res_data = val_a;
        res_req_toggle = ~res_req_toggle;
        wait_valid("viol");
        res_data = val_b;
        res_req_toggle = ~res_req_toggle;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_1);
            check_val("viol_hold_data", out_data, val_a);
            check_val("viol_hold_valid", W'(out_valid), W'(1));
        end
`ifdef CLK1_RX_PROTO_ERR_EN
        check_val("perr_set", W'(proto_err), W'(1));
`endif
        out_ready = 1'b1;
        @(negedge clk_1);
        check_val("viol_acc1_valid", W'(out_valid), W'(0));
        check_val("viol_acc1_ack", W'(res_ack_toggle), W'(1));
        @(negedge clk_1);
        check_val("viol_recap_valid", W'(out_valid), W'(1));
        check_val("viol_recap_data", out_data, val_b);
        @(negedge clk_1);
        check_val("viol_acc2_valid", W'(out_valid), W'(0));
        check_val("viol_acc2_ack", W'(res_ack_toggle), W'(0));
`ifdef CLK1_RX_PROTO_ERR_EN
        repeat (3) @(negedge clk_1);
        check_val("perr_sticky", W'(proto_err), W'(1));
`endif

        // Reset mid-operation: get ack to 1, then reset while VALID
        @(negedge clk_1);
        out_ready = 1'b1;
        res_data = W'({$urandom, $urandom, $urandom});
        res_req_toggle = 1'b1;
        budget = 0;
        while (res_ack_toggle != 1'b1 && budget < 12) begin
            @(negedge clk_1);
            budget++;
        end
        check_val("mrst_pre_ack", W'(res_ack_toggle), W'(1));
        out_ready = 1'b0;
        res_req_toggle = 1'b0;
        wait_valid("mrst");
        check_val("mrst_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", W'(out_valid), W'(0));
        check_val("mrst_busy", W'(busy), W'(0));
        check_val("mrst_ack", W'(res_ack_toggle), W'(0));
        check_val("mrst_data", out_data, W'(0));
`ifdef CLK1_RX_PROTO_ERR_EN
        check_val("mrst_perr", W'(proto_err), W'(0));
`endif
        repeat (2) @(negedge clk_1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_1);
            check_val("mrst_quiet_valid", W'(out_valid), W'(0));
            check_val("mrst_quiet_ack", W'(res_ack_toggle), W'(0));
        end
        out_ready = 1'b0;
        val_a = W'({$urandom, $urandom, $urandom});
        res_data = val_a;
        res_req_toggle = 1'b1;
        wait_valid("mrst_new");
        check_val("mrst_new_data", out_data, val_a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
